// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the instruction-memory read
// handshake and feeds the IF/ID register. Memory latency, downstream stalls
// and redirects are absorbed here so IF/ID only loads live instructions.
module ifetch_stage #(
  parameter int               width    = 16,
  parameter logic [width-1:0] PC_RESET = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall,
  input  logic             redirect,
  input  logic [width-1:0] redirect_pc,
  output logic             imem_read,
  output logic [width-1:0] imem_address,
  input  logic [width-1:0] imem_rdata,
  input  logic             imem_resp,
  output logic             if_id_load,
  output logic             if_id_flush,
  output logic [width-1:0] if_ir,
  output logic [width-1:0] if_pc,
  output logic [width-1:0] if_pc_next
);

  localparam logic [width-1:0] ONE = {{(width-1){1'b0}}, 1'b1};

  // IDLE: one quiet cycle after reset. FETCH: request outstanding at pc.
  // HOLD: instruction buffered while downstream stalls (no request).
  // DROP: finishing a request orphaned by a redirect, address unchanged.
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

  state_t           state, state_n;
  logic [width-1:0] pc, pc_n;
  logic [width-1:0] hold_ir, hold_ir_n;
  logic [width-1:0] drop_addr, drop_addr_n;

  // State and datapath registers; reset abandons any request in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pc        <= PC_RESET;
      hold_ir   <= '0;
      drop_addr <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      hold_ir   <= hold_ir_n;
      drop_addr <= drop_addr_n;
    end
  end

  // Next state and outputs. Priority is redirect > stall > advance; the
  // paths from imem_rdata/stall/redirect to the IF/ID inputs are
  // combinational so a zero-wait memory sustains one instruction per cycle.
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    hold_ir_n    = hold_ir;
    drop_addr_n  = drop_addr;
    imem_read    = 1'b0;
    imem_address = '0;
    if_id_load   = 1'b0;
    if_id_flush  = 1'b0;
    if_ir        = '0;
    case (state)
      IDLE: begin
        state_n = FETCH;
      end
      FETCH: begin
        imem_read    = 1'b1;
        imem_address = pc;
        if_ir        = imem_rdata;
        if_id_flush  = redirect;
        if (imem_resp) begin
          if (redirect) begin
            pc_n = redirect_pc;
          end else if (stall) begin
            hold_ir_n = imem_rdata;
            state_n   = HOLD;
          end else begin
            if_id_load = 1'b1;
            pc_n       = pc + ONE;
          end
        end else if (redirect) begin
          // Request stays open at the old address until memory answers.
          drop_addr_n = pc;
          pc_n        = redirect_pc;
          state_n     = DROP;
        end
      end
      HOLD: begin
        if_ir       = hold_ir;
        if_id_flush = redirect;
        if (redirect) begin
          pc_n    = redirect_pc;
          state_n = FETCH;
        end else if (!stall) begin
          if_id_load = 1'b1;
          pc_n       = pc + ONE;
          state_n    = FETCH;
        end
      end
      DROP: begin
        imem_read    = 1'b1;
        imem_address = drop_addr;
        if_id_flush  = redirect;
        if (redirect) pc_n = redirect_pc;
        if (imem_resp) state_n = FETCH;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign if_pc      = pc;
  assign if_pc_next = pc + ONE;

endmodule

// File: tb/tb_ifetch_stage.sv
// Randomized bench for ifetch_stage: a variable-latency memory model answers
// requests with address ^ 16'h1000, stall/redirect are randomized, and a
// flag-based behavioural model predicts every IF/ID-facing output.
module tb_ifetch_stage;

  localparam logic [15:0] PC_RST = 16'h0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, redirect, imem_resp;
  logic [15:0] redirect_pc, imem_rdata;
  logic        imem_read, if_id_load, if_id_flush;
  logic [15:0] imem_address, if_ir, if_pc, if_pc_next;

  ifetch_stage #(.width(16), .PC_RESET(PC_RST)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_read(imem_read),
    .imem_address(imem_address), .imem_rdata(imem_rdata),
    .imem_resp(imem_resp), .if_id_load(if_id_load),
    .if_id_flush(if_id_flush), .if_ir(if_ir), .if_pc(if_pc),
    .if_pc_next(if_pc_next)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [15:0] got,
                          input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: "started" past the idle cycle, a buffered instruction,
  // and an orphaned request still to be completed.
  logic        m_started, m_buf_valid, m_orphan;
  logic [15:0] m_pc, m_buf, m_orphan_addr;
  // Memory model: cycles elapsed on current request and its latency.
  int          mem_cnt, mem_lat;
  int          max_lat;
  int          p_stall, p_redir;
  logic        did_drop_reset;

  task automatic model_reset();
    m_started = 1'b0; m_buf_valid = 1'b0; m_orphan = 1'b0;
    m_pc = PC_RST; m_buf = '0; m_orphan_addr = '0;
    mem_cnt = 0; mem_lat = 0;
  endtask

  // Drive random inputs for this cycle, answering the memory handshake.
  task automatic drive_inputs();
    stall       = ($urandom_range(99) < p_stall);
    redirect    = ($urandom_range(99) < p_redir);
    redirect_pc = ($urandom_range(3) == 0) ? 16'hFFFF : 16'($urandom);
    #1;
    imem_resp  = imem_read && (mem_cnt >= mem_lat);
    imem_rdata = imem_resp ? (imem_address ^ 16'h1000) : 16'($urandom);
    #1;
  endtask

  task automatic check_outputs();
    logic        e_read, e_load;
    e_read = m_started && !m_buf_valid;
    e_load = m_started && !redirect && !stall &&
             (m_buf_valid || (!m_orphan && imem_resp));
    check_eq("imem_read", 16'(imem_read), 16'(e_read));
    if (e_read)
      check_eq("imem_address", imem_address, m_orphan ? m_orphan_addr : m_pc);
    check_eq("if_id_load", 16'(if_id_load), 16'(e_load));
    if (e_load)
      check_eq("if_ir", if_ir, m_buf_valid ? m_buf : (imem_rdata));
    if (!m_started) check_eq("if_ir_idle", if_ir, 16'h0000);
    check_eq("if_id_flush", 16'(if_id_flush), 16'(m_started && redirect));
    check_eq("if_pc", if_pc, m_pc);
    check_eq("if_pc_next", if_pc_next, m_pc + 16'd1);
  endtask

  // Advance model and memory by one clock using the inputs just applied.
  task automatic model_step();
    logic resp;
    resp = imem_resp;
    if (imem_read) begin
      if (resp) begin
        mem_cnt = 0;
        mem_lat = $urandom_range(max_lat);
      end else begin
        mem_cnt++;
      end
    end
    if (!m_started) begin
      m_started = 1'b1;
    end else if (m_buf_valid) begin
      if (redirect) begin m_pc = redirect_pc; m_buf_valid = 1'b0; end
      else if (!stall) begin m_pc = m_pc + 16'd1; m_buf_valid = 1'b0; end
    end else if (m_orphan) begin
      if (redirect) m_pc = redirect_pc;
      if (resp) m_orphan = 1'b0;
    end else begin
      if (redirect) begin
        if (!resp) begin m_orphan = 1'b1; m_orphan_addr = m_pc; end
        m_pc = redirect_pc;
      end else if (resp) begin
        if (stall) begin m_buf = imem_rdata; m_buf_valid = 1'b1; end
        else m_pc = m_pc + 16'd1;
      end
    end
  endtask

  initial begin
    stall = 0; redirect = 0; redirect_pc = 0; imem_resp = 0; imem_rdata = 0;
    did_drop_reset = 1'b0;
    model_reset();
    max_lat = 0; p_stall = 0; p_redir = 0;
    reset_n = 1'b0;
    #2;
    check_eq("rst_imem_read", 16'(imem_read), 16'h0);
    check_eq("rst_if_id_load", 16'(if_id_load), 16'h0);
    check_eq("rst_if_pc", if_pc, PC_RST);
    check_eq("rst_if_pc_next", if_pc_next, PC_RST + 16'd1);
    @(negedge clk);
    reset_n = 1'b1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      // Straight-line zero-wait fetch first, then full randomization.
      if (cyc == 12) begin max_lat = 3; p_stall = 25; p_redir = 12; end
      drive_inputs();
      check_outputs();
      if (m_orphan && !did_drop_reset && cyc > 200) begin
        // Asynchronous reset while completing an orphaned request.
        reset_n = 1'b0;
        #1;
        check_eq("drop_rst_imem_read", 16'(imem_read), 16'h0);
        check_eq("drop_rst_if_id_load", 16'(if_id_load), 16'h0);
        check_eq("drop_rst_if_pc", if_pc, PC_RST);
        did_drop_reset = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        continue;
      end
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
    check_eq("drop_reset_seen", 16'(did_drop_reset), 16'h1);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ifetch_stage.md
# ifetch_stage

Instruction-fetch stage of the pipelined LC-3 datapath. Owns the program counter, runs the read handshake to instruction memory, and drives the data, load and flush inputs of the IF/ID pipeline register directly downstream. It absorbs memory latency, downstream stalls and branch/jump redirects from later stages, so the IF/ID register only ever loads a valid, non-squashed instruction.

## Interface
- `width`, 16: PC and instruction width.
- `PC_RESET`, 16'h0000: PC value after reset.

- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  downstream cannot accept an instruction this cycle.
- `redirect`  in  1  later stage has resolved a taken branch, jump or trap.
- `redirect_pc`  in  width  target PC, valid when `redirect`=1.
- `imem_read`  out  1  read request to instruction memory.
- `imem_address`  out  width  read address; stable while `imem_read`=1.
- `imem_rdata`  in  width  read data; valid when `imem_resp`=1.
- `imem_resp`  in  1  one-cycle completion pulse for the current request.
- `if_id_load`  out  1  load strobe for the IF/ID register.
- `if_id_flush`  out  1  flush strobe for the IF/ID register.
- `if_ir`  out  width  instruction presented to the IF/ID register.
- `if_pc`  out  width  PC of `if_ir`.
- `if_pc_next`  out  width  `if_pc`+1, modulo 2^width.

## Operation
- Registered state: `pc`, `hold_ir`, `drop_addr`, and a state machine with states IDLE, FETCH, HOLD, DROP.
- Reset values: state=IDLE, `pc`=`PC_RESET`, `hold_ir`=0, `drop_addr`=0. All outputs are 0 in IDLE except `if_pc`=`PC_RESET` and `if_pc_next`=`PC_RESET`+1.
- IDLE: no request. Moves to FETCH on the next clock unconditionally.
- FETCH: `imem_read`=1 and `imem_address`=`pc`.
  - `imem_resp` with `redirect`: drop the data, `pc`<=`redirect_pc`, stay in FETCH.
  - `imem_resp` without `redirect` or `stall`: `if_ir`=`imem_rdata` and `if_id_load`=1 in the same cycle. Then `pc`<=`pc`+1 and the state stays FETCH.
  - `imem_resp` with `stall` and no `redirect`: `hold_ir`<=`imem_rdata`, go to HOLD.
  - No `imem_resp`, with `redirect`: `drop_addr`<=`pc`, `pc`<=`redirect_pc`, go to DROP.
  - No `imem_resp` and no `redirect`: stay in FETCH.
- HOLD: `imem_read`=0 and `if_ir`=`hold_ir`.
  - `redirect`: discard the buffer, `pc`<=`redirect_pc`, go to FETCH.
  - No `redirect` and no `stall`: `if_id_load`=1, `pc`<=`pc`+1, go to FETCH.
  - Otherwise: stay in HOLD.
- DROP: `imem_read`=1 and `imem_address`=`drop_addr`. This completes the orphaned request without changing its address.
  - `imem_resp`: discard the data, go to FETCH.
  - `redirect` (with or without `imem_resp`): `pc`<=`redirect_pc`; the most recent redirect wins.
- `if_id_flush`=`redirect` in every state except IDLE.
- `if_id_load` is never 1 in the same cycle as `redirect` or `stall`.
- `if_pc`=`pc` and `if_pc_next`=`pc`+1, with no saturation. `pc`=16'hFFFF gives `if_pc_next`=16'h0000, and the next fetch address is 16'h0000.
- Priority: `redirect` > `stall` > normal advance.
- `reset_n` low in any state, including mid-request: immediate return to reset values. The memory is responsible for ignoring the abandoned request.

## Timing
- Reset release at edge 0:
  - Edge 1 enters FETCH.
  - `imem_read` is first high in cycle 1.
- Zero-wait memory (`imem_resp` in the same cycle as the request): one instruction per cycle, with `if_id_load` high every cycle.
- N-cycle memory: `if_id_load` is high in the cycle `imem_resp` arrives. The next request starts the following cycle, so there is one instruction per N+1 cycles.
- `if_ir`, `if_pc` and `if_id_load` are valid before the clock edge at which the IF/ID register samples them. Paths from `imem_rdata`, `stall` and `redirect` to these outputs are combinational.
- Redirect:
  - The first request to `redirect_pc` issues the cycle after `redirect` if no request is outstanding.
  - Otherwise it issues the cycle after the orphaned `imem_resp`.
- A HOLD release loads the IF/ID register in the cycle `stall` falls, and the next fetch issues one cycle later.

## Test plan
- **Reset and straight-line fetch:** reset, zero-wait memory returning `imem_rdata`=address XOR 16'h1000. Required: addresses 0,1,2,3 on consecutive cycles from cycle 1; `if_id_load`=1 each cycle; `if_ir`=16'h1000,16'h1001,...
- **Wait states plus stall:** 2-cycle memory, with `stall` high for 3 cycles starting when the response for PC 5 arrives. Required: HOLD with `imem_read`=0; `if_ir` held at the PC-5 data; `if_id_load` pulses once as `stall` falls; next address 6.
- **Redirect with a request outstanding:** redirect to 16'h3000 one cycle into a 3-cycle read of 16'h0004. Required:
  - `if_id_flush`=1 for one cycle.
  - `imem_address` stays 16'h0004 until `imem_resp`.
  - That data is never loaded.
  - The next address is 16'h3000.
- **Redirect in HOLD and simultaneous events:**
  - `redirect` with `stall` in HOLD → buffer discarded, no load, fetch 16'h3000 the next cycle.
  - `redirect` and `imem_resp` in the same FETCH cycle → no load, flush=1.
- **PC wrap:** `redirect_pc`=16'hFFFF. Required: `if_pc`=16'hFFFF, `if_pc_next`=16'h0000, next fetch address 16'h0000.
- **Reset mid-operation:** assert `reset_n` low while in DROP. Required: `imem_read` and `if_id_load` fall immediately; `pc` returns to `PC_RESET`; fetch restarts at `PC_RESET` one cycle after release.
